// File: rtl/replay_fifo.sv
// replay_fifo: receive-side FIFO with speculative reads.
// The consumer pops words speculatively. A commit permanently releases
// everything popped so far. A rewind moves the speculative read pointer back
// to the committed pointer, so uncommitted words are delivered again.
// Writes are always final. All DEPTH entries are usable because each pointer
// carries an extra wrap bit.
module replay_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,      // asynchronous, active-low
    input  logic                   valid_in,
    output logic                   ready_in,
    input  logic [WIDTH-1:0]       data_in,
    input  logic                   ready_out,
    output logic                   valid_out,
    output logic [WIDTH-1:0]       data_out,
    input  logic                   commit,
    input  logic                   rewind,
    output logic [$clog2(DEPTH):0] used,
    output logic [$clog2(DEPTH):0] pending
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] ZERO_P  = PW'(0);
    localparam logic [PW-1:0] ONE_P   = PW'(1);

    // The storage array is intentionally not reset.
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Pointers with the wrap bit in the MSB. rd_q is the committed read
    // pointer; spec_q is the speculative read pointer.
    logic [PW-1:0] wr_q,   wr_d;
    logic [PW-1:0] rd_q,   rd_d;
    logic [PW-1:0] spec_q, spec_d;

    logic full_s;
    logic write_s;
    logic read_s;

    // Status flags, derived only from registered pointers (no same-cycle bypass).
    always_comb begin
        used      = wr_q - rd_q;
        pending   = spec_q - rd_q;
        full_s    = (used == DEPTH_P);
        ready_in  = ~full_s;
        valid_out = (spec_q != wr_q);
        write_s   = valid_in & ~full_s;
        read_s    = ready_out & valid_out;
        data_out  = mem_q[spec_q[AW-1:0]];
    end

    // Next-state pointers. Rewind has priority over commit.
    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        spec_d = spec_q;
        if (write_s) begin
            wr_d = wr_q + ONE_P;
        end else begin
            wr_d = wr_q;
        end
        if (rewind) begin
            // A same-cycle read is discarded. Replay starts from the committed point.
            spec_d = rd_q;
            rd_d   = rd_q;
        end else if (commit) begin
            // A commit also covers a read made in the same cycle.
            spec_d = spec_q + (read_s ? ONE_P : ZERO_P);
            rd_d   = spec_q + (read_s ? ONE_P : ZERO_P);
        end else if (read_s) begin
            spec_d = spec_q + ONE_P;
            rd_d   = rd_q;
        end else begin
            spec_d = spec_q;
            rd_d   = rd_q;
        end
    end

    // Pointer registers, cleared immediately when reset is asserted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q   <= ZERO_P;
            rd_q   <= ZERO_P;
            spec_q <= ZERO_P;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            spec_q <= spec_d;
        end
    end

    // Storage write port. A write occurs regardless of commit or rewind.
    always_ff @(posedge clk) begin
        if (write_s) begin
            mem_q[wr_q[AW-1:0]] <= data_in;
        end
    end

endmodule

// File: tb/tb_replay_fifo.sv
// Self-checking bench for replay_fifo.
// The reference model holds the committed, unreleased words in a queue and
// counts how many of them have been read speculatively.
module tb_replay_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int PW    = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             valid_in = 1'b0;
    logic             ready_in;
    logic [WIDTH-1:0] data_in = 8'h00;
    logic             ready_out = 1'b0;
    logic             valid_out;
    logic [WIDTH-1:0] data_out;
    logic             commit = 1'b0;
    logic             rewind = 1'b0;
    logic [PW-1:0]    used;
    logic [PW-1:0]    pending;

    replay_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .data_in   (data_in),
        .ready_out (ready_out),
        .valid_out (valid_out),
        .data_out  (data_out),
        .commit    (commit),
        .rewind    (rewind),
        .used      (used),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: queue of unreleased words plus a count of speculatively read words.
    logic [WIDTH-1:0] mq [$];
    int pend = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        int sz;
        sz = mq.size();
        chk("valid_out", 32'(valid_out), (pend < sz) ? 32'd1 : 32'd0);
        chk("ready_in",  32'(ready_in),  (sz < DEPTH) ? 32'd1 : 32'd0);
        chk("used",      32'(used),      32'(sz));
        chk("pending",   32'(pending),   32'(pend));
        if (pend < sz) begin
            chk("data_out", 32'(data_out), 32'(mq[pend]));
        end
    endtask

    // One clock cycle: drive inputs, check outputs, then advance the model at the edge.
    task automatic cycle(input logic vi, input logic [WIDTH-1:0] di, input logic ro,
                         input logic cm, input logic rw);
        bit wr;
        bit rd;
        int npop;
        valid_in  = vi;
        data_in   = di;
        ready_out = ro;
        commit    = cm;
        rewind    = rw;
        #1;
        check_model();
        wr = vi && (mq.size() < DEPTH);
        rd = ro && (pend < mq.size());
        @(posedge clk);
        if (rw) begin
            pend = 0;
        end else if (cm) begin
            npop = pend + (rd ? 1 : 0);
            for (int k = 0; k < npop; k++) void'(mq.pop_front());
            pend = 0;
        end else if (rd) begin
            pend++;
        end
        if (wr) mq.push_back(di);
        @(negedge clk);
    endtask

    initial begin
        // Outputs while reset is held.
        #1;
        chk("rst_valid_out", 32'(valid_out), 32'd0);
        chk("rst_ready_in",  32'(ready_in),  32'd1);
        chk("rst_used",      32'(used),      32'd0);
        chk("rst_pending",   32'(pending),   32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Fill with 0x00..0x0F and no reads.
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        #1;
        chk("fill_used",      32'(used),      32'd16);
        chk("fill_ready_in",  32'(ready_in),  32'd0);
        chk("fill_valid_out", 32'(valid_out), 32'd1);
        chk("fill_data_out",  32'(data_out),  32'h00);
        cycle(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        chk("fill17_used", 32'(used), 32'd16);

        // Replay: read four words, then rewind.
        for (int i = 0; i < 4; i++) begin
            chk("replay_data", 32'(data_out), 32'(i));
            cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        chk("replay_pending4", 32'(pending), 32'd4);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("replay_pending0", 32'(pending),  32'd0);
        chk("replay_data0",    32'(data_out), 32'h00);
        chk("replay_used",     32'(used),     32'd16);
        chk("replay_ready_in", 32'(ready_in), 32'd0);

        // Commit four words.
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("commit_used",     32'(used),     32'd12);
        chk("commit_pending",  32'(pending),  32'd0);
        chk("commit_ready_in", 32'(ready_in), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("commit_rewind_data", 32'(data_out), 32'h04);

        // Commit together with a same-cycle read.
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("cmrd_pending", 32'(pending), 32'd0);
        chk("cmrd_used",    32'(used),    32'd9);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("cmrd_rewind_data", 32'(data_out), 32'h07);

        // Commit, rewind and read together: rewind wins.
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        chk("prio_pending", 32'(pending),  32'd0);
        chk("prio_used",    32'(used),     32'd9);
        chk("prio_data",    32'(data_out), 32'h07);

        // Random traffic across pointer wrap.
        for (int i = 0; i < 40; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 8'($urandom),
                  1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 7) == 0));
        end
        cycle(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);

        // Reset mid-stream takes effect without a clock edge.
        valid_in  = 1'b1;
        ready_out = 1'b1;
        reset     = 1'b0;
        #2;
        chk("mid_rst_valid_out", 32'(valid_out), 32'd0);
        chk("mid_rst_used",      32'(used),      32'd0);
        chk("mid_rst_pending",   32'(pending),   32'd0);
        chk("mid_rst_ready_in",  32'(ready_in),  32'd1);
        mq.delete();
        pend = 0;
        @(negedge clk);
        reset = 1'b1;
        cycle(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        chk("post_rst_valid", 32'(valid_out), 32'd1);
        chk("post_rst_data",  32'(data_out),  32'h5A);
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
